// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder: funct3 access-size codes
// and the request FSM state encoding.
package mem_pkg;

  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: load extraction/extension, store-lane merge
// into the current memory word, and the size/alignment error check.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  size,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_word,
  output logic [31:0] rdata,
  output logic [31:0] wr_word,
  output logic        err
);

  logic [31:0] rd_shift;
  logic [31:0] wd_shift;
  logic [3:0]  lane_mask;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    rdata     = '0;
    wr_word   = rd_word;
    err       = 1'b0;
    lane_mask = 4'b0000;
    rd_shift  = rd_word >> {addr_lo, 3'b000};
    wd_shift  = wdata << {addr_lo, 3'b000};

    case (size)
      SIZE_B:  rdata = {{24{rd_shift[7]}}, rd_shift[7:0]};
      SIZE_BU: rdata = {24'h0, rd_shift[7:0]};
      SIZE_H:  rdata = {{16{rd_shift[15]}}, rd_shift[15:0]};
      SIZE_HU: rdata = {16'h0, rd_shift[15:0]};
      SIZE_W:  rdata = rd_word;
      default: rdata = '0;
    endcase

    case (size)
      SIZE_B:  err = 1'b0;
      SIZE_BU: err = we;
      SIZE_H:  err = addr_lo[0];
      SIZE_HU: err = addr_lo[0] | we;
      SIZE_W:  err = |addr_lo;
      default: err = 1'b1;
    endcase

    // Lane width comes from the low two size bits; unsigned store codes are
    // already flagged as errors above, so their mask is never used.
    case (size[1:0])
      2'b00:   lane_mask = 4'b0001 << addr_lo;
      2'b01:   lane_mask = 4'b0011 << addr_lo;
      default: lane_mask = 4'b1111;
    endcase

    for (int i = 0; i < 4; i++) begin
      if (lane_mask[i]) wr_word[i*8 +: 8] = wd_shift[i*8 +: 8];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency load/store responder with valid/ready request and response
// handshakes over a little-endian word-organised memory.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]            req_size,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

  state_t                  state;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [2:0]              size_q;

  logic [DATA_WIDTH-1:0]   mem [WORDS];
  logic [ADDR_WIDTH-3:0]   word_idx;
  logic [DATA_WIDTH-1:0]   align_rdata;
  logic [DATA_WIDTH-1:0]   align_wword;
  logic                    align_err;
  logic                    exec;

  assign req_ready = (state == ST_IDLE) && !rst;
  assign word_idx  = addr_q[ADDR_WIDTH-1:2];
  assign exec      = !rst && (state == ST_WAIT) && (cnt == 4'd0);

  mem_lane_align u_align (
    .addr_lo (addr_q[1:0]),
    .size    (size_q),
    .we      (we_q),
    .wdata   (wdata_q),
    .rd_word (mem[word_idx]),
    .rdata   (align_rdata),
    .wr_word (align_wword),
    .err     (align_err)
  );

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      size_q     <= SIZE_W;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr[ADDR_WIDTH-1:0];
            we_q    <= req_we;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            cnt     <= 4'(LATENCY - 1);
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= align_err;
            resp_rdata <= (align_err || we_q) ? '0 : align_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the storage array has no reset; a store only lands when the access
  // executes, so a reset before that point leaves memory untouched.
  always_ff @(posedge clk) begin
    if (exec && we_q && !align_err) mem[word_idx] <= align_wword;
  end

endmodule
